// File: rtl/adder_display_ctrl.sv
// rtl/adder_display_ctrl.sv - serial nibble adder with atomically committed, multiplexed 7-segment display
module adder_display_ctrl #(
  parameter int NDIG        = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] a,
  input  logic [4*NDIG-1:0] b,
  input  logic              blank,
  output logic              done,
  output logic              carry_out,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [NDIG-1:0]   an
);
  localparam int KW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {IDLE, ADD, COMMIT} state_t;

  state_t            state;
  logic [4*NDIG-1:0] la, lb, sh, sh_next, disp;
  logic [KW-1:0]     k, ptr;
  logic [CW-1:0]     cnt;
  logic              c;
  logic [4:0]        sum;
  logic [3:0]        nib;

  // The last digit's sum is folded into the commit so the buffer updates on the final ADD edge.
  always_comb begin
    sum = {1'b0, la[4*k +: 4]} + {1'b0, lb[4*k +: 4]} + {4'b0000, c};
    sh_next = sh;
    sh_next[4*k +: 4] = sum[3:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      done      <= 1'b0;
      carry_out <= 1'b0;
      la        <= '0;
      lb        <= '0;
      sh        <= '0;
      disp      <= '0;
      k         <= '0;
      c         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            la       <= a;
            lb       <= b;
            k        <= '0;
            c        <= 1'b0;
            in_ready <= 1'b0;
            state    <= ADD;
          end
        end
        ADD: begin
          sh <= sh_next;
          c  <= sum[4];
          k  <= k + 1'b1;
          if (k == KW'(NDIG - 1)) begin
            disp      <= sh_next;
            carry_out <= sum[4];
            done      <= 1'b1;
            state     <= COMMIT;
          end
        end
        COMMIT: begin
          done     <= 1'b0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          done     <= 1'b0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Scanner is free-running; blank only gates the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      ptr <= '0;
    end else if (cnt == CW'(REFRESH_DIV - 1)) begin
      cnt <= '0;
      ptr <= (ptr == KW'(NDIG - 1)) ? '0 : ptr + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    nib = disp[4*ptr +: 4];
    seg = '0;
    case (nib)
      4'h0: seg = 7'b1111110;
      4'h1: seg = 7'b0110000;
      4'h2: seg = 7'b1101101;
      4'h3: seg = 7'b1111001;
      4'h4: seg = 7'b0110011;
      4'h5: seg = 7'b1011011;
      4'h6: seg = 7'b1011111;
      4'h7: seg = 7'b1110000;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1111011;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b0011111;
      4'hC: seg = 7'b1001110;
      4'hD: seg = 7'b0111101;
      4'hE: seg = 7'b1001111;
      4'hF: seg = 7'b1000111;
      default: seg = 7'b0000000;
    endcase
    dp = (nib > 4'd9);
    an = '0;
    an[ptr] = 1'b1;
    if (blank) begin
      seg = '0;
      dp  = 1'b0;
      an  = '0;
    end
  end
endmodule

// File: doc/adder_display_ctrl.md
Name: adder_display_ctrl

Overview:
- Sequencer that time-shares one 4-bit nibble adder and one hex-to-7-segment encoder across NDIG digits.
- Accepts two multi-digit operands over a valid/ready handshake and adds them serially, one nibble per cycle with ripple carry.
- Commits the full result atomically to a display buffer.
- Continuously scans the buffer onto a multiplexed NDIG-digit display.

Parameters:
- NDIG, 4, number of hex digits; operand width is 4*NDIG.
- REFRESH_DIV, 50000, clock cycles each digit stays selected; legal range ≥ 2.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset; sampled on rising edge of clk.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- a  in  4*NDIG  operand A; digit k is a[4k+3:4k].
- b  in  4*NDIG  operand B; same layout.
- blank  in  1  forces display dark; does not affect arithmetic.
- done  out  1  one-cycle pulse, asserted in the cycle after the result is committed.
- carry_out  out  1  carry out of the most significant digit of the last committed result.
- seg  out  7  segments {a,b,c,d,e,f,g}, bit 6 = a, active-high.
- dp  out  1  decimal point of the selected digit, active-high.
- an  out  NDIG  one-hot digit enable, active-high; an[0] = least significant digit.

Behaviour:
- Reset (rst_n=0 at an edge) applies the following, then holds until rst_n=1:
  - FSM to IDLE.
  - Committed buffer and shadow buffer to all zero; carry_out=0; done=0; in_ready=1.
  - Refresh counter to 0 and digit pointer to 0, so an=0…01, seg=1111110, dp=0.
- Reset mid-operation discards the operation in progress. No partial result is ever committed.
- FSM states:
  - IDLE: in_ready=1. When in_valid=1 at an edge, latch a and b, clear the carry and digit index k, and go to ADD. in_valid with in_ready=0 is ignored; the source must hold in_valid.
  - ADD: in_ready=0. Each cycle computes {c, sh[k]} = a[k] + b[k] + c as a 5-bit sum, then k++. Runs exactly NDIG cycles for k = 0..NDIG-1, then goes to COMMIT.
  - COMMIT: in_ready=0. On this edge the committed buffer takes the shadow buffer and carry_out takes the final c, both in the same edge. done=1 for this one cycle only. Next state is IDLE.
- Latency: handshake accepted at edge T; ADD at T+1..T+NDIG; done high in cycle T+NDIG+1; in_ready returns high in cycle T+NDIG+2. Throughput is one operation per NDIG+2 cycles.
- Arithmetic:
  - Modulo-16 per digit, with carry rippling LSB to MSB.
  - Carry out of the MSB digit goes only to carry_out; the result digits are the low 4*NDIG bits of a+b.
  - Example: FFFF+0001 gives buffer 0000, carry_out=1.
- Scanner (runs independently of the FSM and is never stalled):
  - The refresh counter counts 0..REFRESH_DIV-1.
  - When the counter is at REFRESH_DIV-1, the next edge resets it to 0 and advances the digit pointer modulo NDIG; NDIG-1 wraps to 0.
  - an is the one-hot of the digit pointer.
- Encoder, applied to the committed nibble at the digit pointer:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
- dp=1 when the selected committed nibble is greater than 9, otherwise 0.
- seg, dp and an are combinational from the committed buffer, the pointer and blank.
- The display shows only committed data. A commit in the middle of a digit period updates the seg output from the next cycle, with no glitch to the partial shadow buffer.
- blank=1: seg=0000000, dp=0, an=all zero. The scanner keeps counting, so the digit pointer is unchanged relative to the unblanked case.
- in_valid asserted during the COMMIT cycle is not accepted. It is accepted in the following IDLE cycle if still held.

Test Plan:
- Reset, NDIG=4, REFRESH_DIV=4: hold rst_n=0 for 3 cycles, release. Expect an=0001, seg=1111110, dp=0, in_ready=1, done=0, carry_out=0. Expect an to step 0001→0010→0100→1000→0001 every 4 cycles.
- Add 0x1234+0x4321 accepted at T: expect in_ready=0 during T+1..T+5 and done=1 only at T+5. Then the scan shows digits 5,5,5,5 (seg=1011011) with dp=0 and carry_out=0.
- Add 0xFFFF+0x0001: expect the buffer to read 0000, carry_out=1, all digits seg=1111110. Then add 0x0A0C+0x0000: expect digit0 seg=1001110 with dp=1, digit2 seg=1110111 with dp=1, digits 1 and 3 showing 0.
- Capture seg on every cycle of an operation 0x9999+0x1111 that follows a displayed 0x5555 result. Expect seg to change only after the commit edge (to 0xAAAA, carry_out=0). Expect no intermediate digit values to appear.
- Assert rst_n=0 for one cycle in the middle of an ADD. Expect done never to pulse, the buffer to be 0000, and in_ready=1 one cycle after release. Then in_valid held through the COMMIT cycle of a subsequent add must be accepted exactly one cycle later.
- blank=1 for 6 cycles: expect seg=0, dp=0, an=0. On release, expect an to match the pointer value implied by an uninterrupted count.
